mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = signed (mult), 0 = unsigned (multu); captured with start.
REQ-006 op_a  input  32  multiplicand; captured with start.
REQ-007 op_b  input  32  multiplier; captured with start.
REQ-008 busy  output  1  high in LOAD, ITER and FIX.
REQ-009 done  output  1  single-cycle pulse, high only in DONE.
REQ-010 hilo_we  output  1  load strobe for the HI/LO registers; equal to done.
REQ-011 hi  output  32  upper 32 bits of the product.
REQ-012 lo  output  32  lower 32 bits of the product.
REQ-013 count  output  6  iteration counter; 0 outside ITER.

Function
REQ-014 States: IDLE, LOAD, ITER, FIX, DONE; one-hot or binary encoding is free.
REQ-015 IDLE: on start=1 at edge N, capture op_a, op_b and signed_op, then go to LOAD; start=0 stays in IDLE.
REQ-016 start in any state other than IDLE is ignored; no queueing and no restart.
REQ-017 Operand inputs may change after edge N with no effect on the running operation.
REQ-018 LOAD (one cycle):
- signed_op=1: take the magnitudes |a| and |b| as 32-bit unsigned values; record neg = sign(a) XOR sign(b).
- signed_op=0: use a and b as-is; neg = 0.
- Clear the 64-bit accumulator; count = 0; go to ITER.
REQ-019 ITER, one radix-2 shift-add step per cycle:
- If multiplier bit 0 = 1, add the multiplicand into accumulator[63:32] with a 33-bit carry.
- Shift {carry, accumulator} right by 1.
- count increments by 1.
- Leave ITER on the edge where count reaches 32; exactly 32 cycles are spent in ITER.
REQ-020 FIX (one cycle): if neg=1, the product becomes its 64-bit two's complement, otherwise it is unchanged; go to DONE.
REQ-021 DONE (one cycle): hi/lo take the final product on the edge entering DONE; done=hilo_we=1; next edge returns to IDLE.
REQ-022 Latency: start sampled at edge N gives done=1 in the cycle after edge N+34, and hi/lo valid from that edge.
REQ-023 Back-to-back: the earliest next start is sampled in IDLE at edge N+36.
REQ-024 hi/lo hold their value until the next DONE or reset; they are not disturbed during a later operation.
REQ-025 Arithmetic boundaries:
- |-2^31| = 0x80000000 is held as an unsigned 32-bit magnitude; no overflow is flagged.
- The 64-bit result is always exact.
- A zero operand gives 0 with neg ignored (no negative zero).
REQ-026 busy=1 and done=1 are never asserted in the same cycle.

Reset
REQ-027 reset=1 at any edge forces IDLE, regardless of state, including mid-ITER.
REQ-028 reset=1 clears hi, lo, the accumulator, the operand registers, neg and count to 0, and drives busy, done and hilo_we to 0.
REQ-029 An operation interrupted by reset produces no done pulse and no hi/lo update.
REQ-030 reset has priority over a simultaneous start; start is accepted only at an edge with reset=0.

Verification
REQ-031 Unsigned small: signed_op=0, a=3, b=5, start at edge N -> done=1 after edge N+34, hi=0x00000000, lo=0x0000000F, busy low in the done cycle.
REQ-032 Unsigned max: a=b=0xFFFFFFFF, signed_op=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Signed mixed: a=0xFFFFFFFF (-1), b=7, signed_op=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9; the same operands with signed_op=0 -> hi=0x00000006, lo=0xFFFFFFF9.
REQ-034 Signed extreme: a=b=0x80000000, signed_op=1 -> hi=0x40000000, lo=0x00000000; a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-035 Busy start: start pulsed at count=5 with new operands -> ignored; the first result is unchanged; done pulses exactly once.
REQ-036 Reset mid-op: reset at count=10 -> next cycle IDLE, busy=0, count=0, hi=lo=0, no done; a following start with a=2, b=9 -> lo=0x00000012 after 34 edges.

Source files
------------

// File: rtl/mult_sequencer.sv
// Sequential 32x32 -> 64 multiplier with signed and unsigned modes.
// One radix-2 shift-add step per cycle. The result goes to HI/LO on the
// edge that enters DONE.
module mult_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [5:0]       count
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_signed;
  logic               r_neg;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               w_last_iter;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [AW-1:0]      w_product;

  assign w_last_iter = (r_count == CW'(WIDTH - 1));
  assign w_addend    = r_mplier[0] ? {1'b0, r_mcand} : '0;
  assign w_sum       = {1'b0, r_acc[AW-1:WIDTH]} + w_addend;
  // A zero magnitude negates to zero, so a negative zero cannot occur.
  assign w_product   = r_neg ? (~r_acc + AW'(1)) : r_acc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_ITER;
      S_ITER:  if (w_last_iter) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state, so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_LOAD) || (w_state_next == S_ITER) ||
                (w_state_next == S_FIX);
      r_done <= (w_state_next == S_DONE);
    end
  end

  // Datapath: capture, magnitude conversion, shift-add, sign fix, HI/LO load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_signed <= signed_op;
          end
        end
        S_LOAD: begin
          if (r_signed) begin
            // The magnitude of -2^31 is 0x80000000 when read as unsigned.
            r_mcand  <= r_mcand[WIDTH-1]  ? (~r_mcand + WIDTH'(1))  : r_mcand;
            r_mplier <= r_mplier[WIDTH-1] ? (~r_mplier + WIDTH'(1)) : r_mplier;
            r_neg    <= r_mcand[WIDTH-1] ^ r_mplier[WIDTH-1];
          end else begin
            r_neg    <= 1'b0;
          end
          r_acc   <= '0;
          r_count <= '0;
        end
        S_ITER: begin
          r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          // The counter returns to zero on the final step, so it reads 0 outside ITER.
          r_count  <= w_last_iter ? '0 : r_count + CW'(1);
        end
        S_FIX: begin
          r_acc <= w_product;
          r_hi  <= w_product[AW-1:WIDTH];
          r_lo  <= w_product[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign hilo_we = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign count   = r_count;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer.
module tb_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hilo_we   (hilo_we),
    .hi        (hi),
    .lo        (lo),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for one edge (edge N), then scrambles the operand inputs.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a      = a;
    op_b      = b;
    signed_op = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
    signed_op = ~s;
  endtask

  // Counts edges after edge N until done is seen, giving up after 40.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    op_a  = 32'h0000_0003;
    op_b  = 32'h0000_0005;
    tick();
    tick();
    checks++;
    if ({busy, done, hilo_we, count, hi, lo} !== 73'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b we=%b count=%0d hi=%h lo=%h, required all zero",
               busy, done, hilo_we, count, hi, lo);
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_latency();
    int cyc;
    start_op(32'd3, 32'd5, 1'b0);
    checks++;
    if (busy !== 1'b1 || count !== 6'd0) begin
      errors++;
      $display("FAIL load_state: busy=%b count=%0d, required busy=1 count=0", busy, count);
    end
    tick();
    tick();
    checks++;
    if (count !== 6'd1) begin
      errors++;
      $display("FAIL count_step: count=%0d, required 1", count);
    end
    repeat (31) tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL fix_state: busy=%b done=%b count=%0d, required 1 0 0", busy, done, count);
    end
    tick();
    checks++;
    if (done !== 1'b1 || hilo_we !== 1'b1 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'hF) begin
      errors++;
      $display("FAIL latency_3x5: done=%b we=%b busy=%b hi=%h lo=%h, required 1 1 0 00000000 0000000f",
               done, hilo_we, busy, hi, lo);
    end
    tick();
    checks++;
    if (done !== 1'b0 || hilo_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b we=%b busy=%b, required 0 0 0", done, hilo_we, busy);
    end
    // Back-to-back start at edge N+36; HI/LO must hold the old product meanwhile.
    start_op(32'd7, 32'd9, 1'b0);
    repeat (15) tick();
    checks++;
    if (hi !== 32'h0 || lo !== 32'hF) begin
      errors++;
      $display("FAIL hold_hilo: hi=%h lo=%h, required 00000000 0000000f", hi, lo);
    end
    wait_done(cyc);
    cyc += 15;
    checks++;
    if (cyc !== 34 || hi !== 32'h0 || lo !== 32'h3F) begin
      errors++;
      $display("FAIL back_to_back: cycles=%0d hi=%h lo=%h, required 34 00000000 0000003f", cyc, hi, lo);
    end
    tick();
  endtask

  task automatic test_unsigned();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] eh [4];
    logic [31:0] el [4];
    int cyc;
    va = '{32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vb = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0007, 32'h1234_5678};
    eh = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0006, 32'h0000_0000};
    el = '{32'h0000_000F, 32'h0000_0001, 32'hFFFF_FFF9, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc !== 34 || hi !== eh[i] || lo !== el[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL unsigned_%0d: cycles=%0d busy=%b hi=%h lo=%h, required 34 0 %h %h",
                 i, cyc, busy, hi, lo, eh[i], el[i]);
      end
      tick();
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] eh [5];
    logic [31:0] el [5];
    int cyc;
    va = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFE};
    vb = '{32'h0000_0007, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    eh = '{32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    el = '{32'hFFFF_FFF9, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0006};
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], 1'b1);
      wait_done(cyc);
      checks++;
      if (cyc !== 34 || hi !== eh[i] || lo !== el[i]) begin
        errors++;
        $display("FAIL signed_%0d: cycles=%0d hi=%h lo=%h, required 34 %h %h",
                 i, cyc, hi, lo, eh[i], el[i]);
      end
      tick();
    end
  endtask

  task automatic test_busy_start();
    int pulses;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;
    pulses = 0;
    cap_hi = 32'hDEAD_BEEF;
    cap_lo = 32'hDEAD_BEEF;
    start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
    repeat (6) tick();
    checks++;
    if (count !== 6'd5) begin
      errors++;
      $display("FAIL busy_count: count=%0d, required 5", count);
    end
    op_a      = 32'h0000_1111;
    op_b      = 32'h0000_2222;
    signed_op = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (done === 1'b1) begin
        pulses++;
        cap_hi = hi;
        cap_lo = lo;
      end
      tick();
    end
    checks++;
    if (pulses !== 1 || cap_hi !== 32'h0 || cap_lo !== 32'h200 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: pulses=%0d hi=%h lo=%h busy=%b, required 1 00000000 00000200 0",
               pulses, cap_hi, cap_lo, busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int cyc;
    pulses = 0;
    start_op(32'h0000_1234, 32'h0000_5678, 1'b0);
    repeat (11) tick();
    checks++;
    if (count !== 6'd10) begin
      errors++;
      $display("FAIL mid_count: count=%0d, required 10", count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || count !== 6'd0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b count=%0d hi=%h lo=%h done=%b, required 0 0 0 0 0",
               busy, count, hi, lo, done);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_done: active cycles=%0d, required 0", pulses);
    end
    start_op(32'd2, 32'd9, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 34 || hi !== 32'h0 || lo !== 32'h12) begin
      errors++;
      $display("FAIL after_reset: cycles=%0d hi=%h lo=%h, required 34 00000000 00000012", cyc, hi, lo);
    end
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    op_a      = '0;
    op_b      = '0;
    test_reset();
    test_latency();
    test_unsigned();
    test_signed();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
